// File: rtl/c432_pattern_sequencer.sv
// Pattern sequencer for a c432 under test: applies stored vectors, waits for settling,
// compares against golden responses. Optional response MISR under C432_SEQ_SIGNATURE_EN.
module c432_pattern_sequencer #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pat_valid,
   output logic             pat_ready,
   input  logic [35:0]      pat_data,
   input  logic [6:0]       pat_golden,
   input  logic             pat_last,
   output logic [35:0]      dut_in,
   input  logic [6:0]       dut_resp,
   output logic             busy,
   output logic             done,
   output logic             fail_flag,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [15:0]      signature
);

   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, CAPTURE} state_t;

   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

   state_t           state_q, state_d;
   logic [7:0]       timer_q;
   logic [6:0]       golden_q;
   logic             last_q;
   logic [CNT_W-1:0] idx_q;
   logic             accept, capture, clear, mismatch;

   always_comb begin
      state_d   = state_q;
      pat_ready = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            pat_ready = 1'b1;
            if (pat_valid) begin
               accept  = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (timer_q == 8'd1) state_d = CAPTURE;
         end
         CAPTURE: begin
            capture = 1'b1;
            state_d = last_q ? IDLE : LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign clear    = (state_q == IDLE) && start;
   assign mismatch = (dut_resp != golden_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         timer_q        <= 8'd0;
         golden_q       <= 7'd0;
         last_q         <= 1'b0;
         idx_q          <= '0;
         dut_in         <= 36'd0;
         done           <= 1'b0;
         fail_flag      <= 1'b0;
         mismatch_cnt   <= '0;
         first_fail_idx <= '0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            done           <= 1'b0;
            fail_flag      <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            idx_q          <= '0;
         end
         if (accept) begin
            dut_in   <= pat_data;
            golden_q <= pat_golden;
            last_q   <= pat_last;
            timer_q  <= SETTLE_LD;
         end else if (state_q == SETTLE) begin
            timer_q <= timer_q - 8'd1;
         end
         if (capture) begin
            idx_q <= idx_q + 1'b1;
            if (mismatch) begin
               if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
               // only the first failure of a run is recorded
               if (!fail_flag) begin
                  fail_flag      <= 1'b1;
                  first_fail_idx <= idx_q;
               end
            end
            if (last_q) done <= 1'b1;
         end
      end
   end

`ifdef C432_SEQ_SIGNATURE_EN
   logic [15:0] sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 16'd0;
      end else if (clear) begin
         sig_q <= 16'd0;
      end else if (capture) begin
         sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ {9'd0, dut_resp};
      end
   end

   assign signature = sig_q;
`else
   assign signature = 16'd0;
`endif

endmodule

// File: tb/tb_c432_pattern_sequencer.sv
// Randomized bench for c432_pattern_sequencer: a per-run timeline model predicts every output
// cycle by cycle; directed runs pin latency, saturation, wrap and mid-run reset.
module tb_c432_pattern_sequencer;

   localparam int unsigned SETTLE = 2;
   localparam int unsigned CW     = 4;
   localparam int MAXC = 512;
   localparam int MAXP = 32;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, pat_valid = 1'b0, pat_last = 1'b0;
   logic [35:0]   pat_data = '0;
   logic [6:0]    pat_golden = '0, dut_resp = '0;
   logic          pat_ready, busy, done, fail_flag;
   logic [35:0]   dut_in;
   logic [CW-1:0] mismatch_cnt, first_fail_idx;
   logic [15:0]   signature;

   always #5 clk = ~clk;

   c432_pattern_sequencer #(.SETTLE_CYC(SETTLE), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready),
      .pat_data(pat_data), .pat_golden(pat_golden), .pat_last(pat_last), .dut_in(dut_in),
      .dut_resp(dut_resp), .busy(busy), .done(done), .fail_flag(fail_flag),
      .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx), .signature(signature)
   );

   int total = 0, bad = 0;

   // run description
   int          np;
   logic [35:0] p_data[MAXP];
   logic [6:0]  p_gold[MAXP], p_resp[MAXP];
   int          p_stall[MAXP];

   // per-cycle stimulus and expectations, cycle 1 = first cycle after the start edge
   int            tl_len;
   logic [35:0]   d_data[MAXC];
   logic [6:0]    d_gold[MAXC], d_resp[MAXC];
   logic          d_valid[MAXC], d_last[MAXC], d_start[MAXC];
   logic          e_busy[MAXC], e_ready[MAXC], e_done[MAXC], e_ff[MAXC];
   logic [35:0]   e_din[MAXC];
   logic [CW-1:0] e_cnt[MAXC], e_ffi[MAXC];
   logic [15:0]   e_sig[MAXC];

   // architectural state carried between runs
   logic [35:0]   m_din = '0;
   logic [CW-1:0] m_cnt = '0, m_ffi = '0;
   logic          m_ff = 1'b0, m_done = 1'b0;
   logic [15:0]   m_sig = '0;

   int cyc = 0;
   int first_done = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   function automatic void set_exp(input int t, input logic b, input logic r);
      e_busy[t] = b;  e_ready[t] = r;  e_din[t] = m_din;  e_done[t] = m_done;
      e_cnt[t]  = m_cnt;  e_ffi[t] = m_ffi;  e_ff[t] = m_ff;  e_sig[t] = m_sig;
   endfunction

   function automatic void drv(input int t, input int k, input logic v);
      d_valid[t] = v;  d_start[t] = 1'b0;  d_data[t] = p_data[k];
      d_gold[t]  = p_gold[k];  d_resp[t] = p_resp[k];  d_last[t] = (k == np - 1);
   endfunction

   // Timeline per pattern: stalls in LOAD, one handshake, SETTLE settle cycles, one capture.
   task automatic build();
      int t = 1;
      m_cnt = '0;  m_ffi = '0;  m_ff = 1'b0;  m_done = 1'b0;  m_sig = '0;
      for (int k = 0; k < np; k++) begin
         for (int s = 0; s < p_stall[k]; s++) begin drv(t, k, 1'b0); set_exp(t, 1'b1, 1'b1); t++; end
         drv(t, k, 1'b1); set_exp(t, 1'b1, 1'b1); t++;
         m_din = p_data[k];
         for (int s = 0; s < int'(SETTLE); s++) begin drv(t, k, 1'b0); set_exp(t, 1'b1, 1'b0); t++; end
         drv(t, k, 1'b0); set_exp(t, 1'b1, 1'b0); t++;
         if (p_resp[k] != p_gold[k]) begin
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
            if (!m_ff) begin m_ff = 1'b1; m_ffi = CW'(k); end
         end
`ifdef C432_SEQ_SIGNATURE_EN
         m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {9'd0, p_resp[k]};
`endif
         if (k == np - 1) m_done = 1'b1;
      end
      for (int s = 0; s < 3; s++) begin drv(t, np - 1, 1'b0); set_exp(t, 1'b0, 1'b0); t++; end
      tl_len = t;
   endtask

   task automatic run(input int stop_at);
      @(posedge clk); #1;
      start = 1'b1;  pat_valid = 1'b0;  first_done = -1;
      for (int t = 1; t < tl_len && t <= stop_at; t++) begin
         @(posedge clk); #1;
         cyc = t;  start = d_start[t];  pat_valid = d_valid[t];  pat_data = d_data[t];
         pat_golden = d_gold[t];  pat_last = d_last[t];  dut_resp = d_resp[t];
      end
      @(negedge clk); #1;
      cyc = 0;
   endtask

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("busy", 64'(busy), 64'(e_busy[cyc]));
         chk("pat_ready", 64'(pat_ready), 64'(e_ready[cyc]));
         chk("dut_in", 64'(dut_in), 64'(e_din[cyc]));
         chk("done", 64'(done), 64'(e_done[cyc]));
         chk("mismatch_cnt", 64'(mismatch_cnt), 64'(e_cnt[cyc]));
         chk("first_fail_idx", 64'(first_fail_idx), 64'(e_ffi[cyc]));
         chk("fail_flag", 64'(fail_flag), 64'(e_ff[cyc]));
         chk("signature", 64'(signature), 64'(e_sig[cyc]));
         if (done && first_done < 0) first_done = cyc;
      end
   end

   // mis = bitmask of mismatching pattern indices (only for small directed runs)
   task automatic make_run(input int n, input logic [31:0] mis, input int all_mis);
      np = n;
      for (int k = 0; k < n; k++) begin
         p_data[k]  = {4'($urandom), $urandom};
         p_gold[k]  = 7'($urandom);
         p_stall[k] = 0;
         if (all_mis != 0 || (k < 32 && mis[k]))
            p_resp[k] = p_gold[k] ^ 7'($urandom_range(1, 127));
         else
            p_resp[k] = p_gold[k];
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(pat_ready), 64'd0);
      chk("rst_dut_in", 64'(dut_in), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_cnt", 64'(mismatch_cnt), 64'd0);
      chk("rst_sig", 64'(signature), 64'd0);
      rst_n = 1'b1;

      // three matching patterns: done observed after 12 edges
      make_run(3, 32'h0, 0);
      build(); run(MAXC);
      chk("done_cycle_3pat", 64'(first_done), 64'd13);
      chk("clean_cnt", 64'(mismatch_cnt), 64'd0);
      chk("clean_ff", 64'(fail_flag), 64'd0);

      // patterns 1 and 3 mismatch
      make_run(5, 32'b01010, 0);
      build(); run(MAXC);
      chk("two_mis_cnt", 64'(mismatch_cnt), 64'd2);
      chk("two_mis_ffi", 64'(first_fail_idx), 64'd1);
      chk("two_mis_ff", 64'(fail_flag), 64'd1);

      // 4-cycle source stall before pattern 1, start pulsed mid-run
      make_run(2, 32'b01, 0);
      p_stall[1] = 4;
      build();
      d_start[2] = 1'b1;  d_start[7] = 1'b1;
      run(MAXC);
      chk("stall_done_cycle", 64'(first_done), 64'd13);
      chk("stall_cnt", 64'(mismatch_cnt), 64'd1);

      // 17 mismatches saturate a 4-bit counter
      make_run(17, 32'h0, 1);
      build(); run(MAXC);
      chk("sat_cnt", 64'(mismatch_cnt), 64'd15);
      chk("sat_ffi", 64'(first_fail_idx), 64'd0);

      // index 17 wraps to 1
      make_run(18, 32'h0, 0);
      p_resp[17] = p_gold[17] ^ 7'h40;
      build(); run(MAXC);
      chk("wrap_ffi", 64'(first_fail_idx), 64'd1);
      chk("wrap_cnt", 64'(mismatch_cnt), 64'd1);

      // reset asserted while pattern 1 is settling
      make_run(3, 32'b001, 0);
      build(); run(6);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_dut_in", 64'(dut_in), 64'd0);
      chk("midrst_cnt", 64'(mismatch_cnt), 64'd0);
      chk("midrst_ready", 64'(pat_ready), 64'd0);
      chk("midrst_ff", 64'(fail_flag), 64'd0);
      #1;
      rst_n = 1'b1;
      m_din = '0;  m_cnt = '0;  m_ffi = '0;  m_ff = 1'b0;  m_done = 1'b0;  m_sig = '0;

      // randomized runs, the first one directly after the reset
      for (int r = 0; r < 10; r++) begin
         np = $urandom_range(1, 20);
         for (int k = 0; k < np; k++) begin
            p_data[k]  = {4'($urandom), $urandom};
            p_gold[k]  = 7'($urandom);
            p_resp[k]  = ($urandom_range(0, 2) == 0) ? (p_gold[k] ^ 7'($urandom_range(1, 127)))
                                                     : p_gold[k];
            p_stall[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         end
         build();
         if (r % 2 == 1) d_start[$urandom_range(1, tl_len - 4)] = 1'b1;
         run(MAXC);
         chk("rand_done_seen", 64'(first_done > 0), 64'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/c432_pattern_sequencer.md
C432_PATTERN_SEQUENCER -- requirements
Module: c432_pattern_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, the number of cycles the DUT inputs are held stable before the response is sampled (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, the width of the pattern index and mismatch counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a test run.
REQ-006 SHALL have port pat_valid  input  1  the pattern source holds a valid pattern.
REQ-007 SHALL have port pat_ready  output  1  the sequencer accepts a pattern this cycle.
REQ-008 SHALL have port pat_data  input  36  the stimulus vector, bit 0 = N1 through bit 35 = N115 in c432 input order.
REQ-009 SHALL have port pat_golden  input  7  the expected response {N432,N431,N430,N421,N370,N329,N223}.
REQ-010 SHALL have port pat_last  input  1  marks the final pattern of the run.
REQ-011 SHALL have port dut_in  output  36  the registered stimulus driven to the c432 under test.
REQ-012 SHALL have port dut_resp  input  7  the c432 response, same bit order as pat_golden.
REQ-013 SHALL have port busy  output  1  a run is in progress.
REQ-014 SHALL have port done  output  1  the run has completed; held until the next accepted start.
REQ-015 SHALL have port fail_flag  output  1  at least one mismatch occurred in the run.
REQ-016 SHALL have port mismatch_cnt  output  CNT_W  the number of mismatching patterns.
REQ-017 SHALL have port first_fail_idx  output  CNT_W  the index of the first mismatching pattern.
REQ-018 SHALL have port signature  output  16  the response MISR value (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, SETTLE and CAPTURE; busy SHALL be 1 in every state except IDLE.
REQ-020 IDLE: start=1 SHALL move the FSM to LOAD and clear done, fail_flag, mismatch_cnt, first_fail_idx, the pattern index and signature.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 LOAD: pat_ready SHALL be 1; pat_valid&pat_ready SHALL latch pat_data into dut_in, and latch pat_golden and pat_last, then move to SETTLE with the timer loaded to SETTLE_CYC.
REQ-023 pat_ready SHALL be 0 in every state except LOAD; the source may hold pat_valid without being consumed.
REQ-024 SETTLE SHALL last exactly SETTLE_CYC cycles with dut_in stable, then move to CAPTURE.
REQ-025 CAPTURE (one cycle) SHALL compare dut_resp with the latched golden value; on inequality, mismatch_cnt SHALL increment, saturating at all-ones.
REQ-026 On the first mismatch of a run, first_fail_idx SHALL take the current pattern index and fail_flag SHALL go to 1; neither SHALL change on later mismatches.
REQ-027 CAPTURE SHALL increment the pattern index, wrapping modulo 2^CNT_W.
REQ-028 CAPTURE SHALL go to IDLE and set done=1 when the latched last flag is 1, and SHALL otherwise go to LOAD.
REQ-029 Minimum per-pattern period SHALL be SETTLE_CYC+2 cycles: one handshake cycle, SETTLE_CYC settle cycles and one capture cycle.
REQ-030 dut_in SHALL retain its last value in IDLE.

Reset
REQ-031 rst_n=0 SHALL, asynchronously and at any point including mid-run, force IDLE and set dut_in, every counter, signature, done, fail_flag, busy and pat_ready to 0.
REQ-032 After rst_n deasserts, the first start SHALL be accepted no earlier than the next rising edge.

Configuration
REQ-033 With macro C432_SEQ_SIGNATURE_EN defined, signature SHALL be a 16-bit MISR (polynomial x^16+x^12+x^5+1), updated in CAPTURE with dut_resp XORed into bits 6:0; with the macro undefined, signature SHALL be constant 0 and no MISR logic SHALL be present.

Verification
REQ-034 Reset mid-SETTLE -> busy=0, dut_in=0 and mismatch_cnt=0 immediately; the next start runs normally.
REQ-035 3 patterns, all responses matching golden, SETTLE_CYC=2 -> done=1 at cycle 12 after start, mismatch_cnt=0, fail_flag=0.
REQ-036 5 patterns with patterns 1 and 3 mismatching -> mismatch_cnt=2, first_fail_idx=1, fail_flag=1.
REQ-037 pat_valid low for 4 cycles in LOAD -> FSM stays in LOAD with pat_ready=1 and dut_in unchanged; the run resumes on pat_valid=1.
REQ-038 start pulsed mid-run -> ignored, and counters are not cleared; a CNT_W=4 run with 17 mismatching patterns -> mismatch_cnt=15 (saturated) and the pattern index wraps to 1.
